rs_bank: RTL

Multi-entry reservation station bank for the P6-style out-of-order core. It replaces per-entry instantiation with a parametrised array that handles:
- allocation from dispatch;
- operand capture from several CDB ports;
- select of one ready entry per cycle toward execute.

It sits between dispatch/map-table/ROB and the issue stage.

---
 rtl/rs_pkg.sv | 18 +
 rtl/rs_bank_if.sv | 65 ++++++
 rtl/rs_slot.sv | 96 +++++++++
 rtl/rs_bank.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station bank.
// Provides the default tag and operand widths, the reserved "no tag" value
// and the source-operand record stored by every entry.
package rs_pkg;

  localparam int unsigned RS_TAG_W = 5;
  localparam int unsigned RS_XLEN  = 32;

  // Tag 0 means "no producer" and must never match a CDB broadcast.
  localparam logic [RS_TAG_W-1:0] RS_TAG_NONE = '0;

  typedef struct packed {
    logic                pending;
    logic [RS_TAG_W-1:0] tag;
    logic [RS_XLEN-1:0]  value;
  } rs_src_t;

endpackage

// File: rtl/rs_bank_if.sv
// Handshake/bus bundle between dispatch, the CDB, the issue stage and rs_bank.
// Groups: squash, allocate request (alloc_*), CDB broadcast (cdb_*),
// issue response (issue_*), and the free-entry count.
// slave: the reservation-station side; master: the surrounding pipeline.
interface rs_bank_if #(
  parameter int unsigned RS_SIZE   = 8,
  parameter int unsigned CDB_NUM   = 2,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PAYLOAD_W = 96
);

  localparam int unsigned CNT_W = $clog2(RS_SIZE) + 1;

  logic                     squash;

  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [PAYLOAD_W-1:0]     alloc_payload;
  logic [TAG_W-1:0]         alloc_dest_tag;
  logic                     alloc_rs1_pending;
  logic                     alloc_rs2_pending;
  logic [TAG_W-1:0]         alloc_rs1_tag;
  logic [TAG_W-1:0]         alloc_rs2_tag;
  logic [XLEN-1:0]          alloc_rs1_value;
  logic [XLEN-1:0]          alloc_rs2_value;

  logic [CDB_NUM-1:0]       cdb_valid;
  logic [CDB_NUM*TAG_W-1:0] cdb_tag;
  logic [CDB_NUM*XLEN-1:0]  cdb_value;

  logic                     issue_valid;
  logic                     issue_ready;
  logic [PAYLOAD_W-1:0]     issue_payload;
  logic [TAG_W-1:0]         issue_dest_tag;
  logic [XLEN-1:0]          issue_rs1_value;
  logic [XLEN-1:0]          issue_rs2_value;

  logic [CNT_W-1:0]         free_count;

  modport slave (
    input  squash,
    input  alloc_valid, alloc_payload, alloc_dest_tag,
    input  alloc_rs1_pending, alloc_rs2_pending, alloc_rs1_tag, alloc_rs2_tag,
    input  alloc_rs1_value, alloc_rs2_value,
    output alloc_ready,
    input  cdb_valid, cdb_tag, cdb_value,
    output issue_valid, issue_payload, issue_dest_tag, issue_rs1_value, issue_rs2_value,
    input  issue_ready,
    output free_count
  );

  modport master (
    output squash,
    output alloc_valid, alloc_payload, alloc_dest_tag,
    output alloc_rs1_pending, alloc_rs2_pending, alloc_rs1_tag, alloc_rs2_tag,
    output alloc_rs1_value, alloc_rs2_value,
    input  alloc_ready,
    output cdb_valid, cdb_tag, cdb_value,
    input  issue_valid, issue_payload, issue_dest_tag, issue_rs1_value, issue_rs2_value,
    output issue_ready,
    input  free_count
  );

endinterface

// File: rtl/rs_slot.sv
// One reservation-station entry: storage, CDB wakeup and same-cycle bypass.
// Ports:
//   clk_i, rst_i (sync, active-high), squash_i  - clock, reset, flush
//   alloc_we_i + alloc_*_i                      - write this entry (one-hot from bank)
//   cdb_valid_i/cdb_tag_i/cdb_value_i           - flattened CDB broadcast ports
//   issue_clr_i                                 - entry was issued, free it
//   busy_o, ready_o, payload_o, dest_tag_o,
//   rs1_value_o, rs2_value_o                    - registered entry state
module rs_slot
  import rs_pkg::*;
#(
  parameter int unsigned CDB_NUM   = 2,
  parameter int unsigned PAYLOAD_W = 96
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        squash_i,
  input  logic                        alloc_we_i,
  input  logic [PAYLOAD_W-1:0]        alloc_payload_i,
  input  logic [RS_TAG_W-1:0]         alloc_dest_tag_i,
  input  rs_src_t                     alloc_rs1_i,
  input  rs_src_t                     alloc_rs2_i,
  input  logic [CDB_NUM-1:0]          cdb_valid_i,
  input  logic [CDB_NUM*RS_TAG_W-1:0] cdb_tag_i,
  input  logic [CDB_NUM*RS_XLEN-1:0]  cdb_value_i,
  input  logic                        issue_clr_i,
  output logic                        busy_o,
  output logic                        ready_o,
  output logic [PAYLOAD_W-1:0]        payload_o,
  output logic [RS_TAG_W-1:0]         dest_tag_o,
  output logic [RS_XLEN-1:0]          rs1_value_o,
  output logic [RS_XLEN-1:0]          rs2_value_o
);

  logic                 busy_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [RS_TAG_W-1:0]  dest_q;
  rs_src_t              rs1_q, rs1_d;
  rs_src_t              rs2_q, rs2_d;

  // Lowest-index matching port wins; RS_TAG_NONE never matches.
  function automatic rs_src_t wake(rs_src_t s, logic [CDB_NUM-1:0] v,
                                   logic [CDB_NUM*RS_TAG_W-1:0] t,
                                   logic [CDB_NUM*RS_XLEN-1:0] d);
    rs_src_t r;
    logic    hit;
    r   = s;
    hit = 1'b0;
    for (int unsigned p = 0; p < CDB_NUM; p++) begin
      if (!hit && s.pending && (s.tag != RS_TAG_NONE) && v[p] &&
          (t[p*RS_TAG_W +: RS_TAG_W] == s.tag)) begin
        hit       = 1'b1;
        r.pending = 1'b0;
        r.value   = d[p*RS_XLEN +: RS_XLEN];
      end
    end
    return r;
  endfunction

  // The same compare serves both wakeup of stored sources and bypass of
  // sources arriving with this cycle's allocation.
  always_comb begin
    rs1_d = wake(alloc_we_i ? alloc_rs1_i : rs1_q, cdb_valid_i, cdb_tag_i, cdb_value_i);
    rs2_d = wake(alloc_we_i ? alloc_rs2_i : rs2_q, cdb_valid_i, cdb_tag_i, cdb_value_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      payload_q <= '0;
      dest_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else if (squash_i) begin
      busy_q <= 1'b0;
    end else begin
      if (alloc_we_i) begin
        busy_q    <= 1'b1;
        payload_q <= alloc_payload_i;
        dest_q    <= alloc_dest_tag_i;
      end else if (issue_clr_i) begin
        busy_q <= 1'b0;
      end
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  assign busy_o      = busy_q;
  assign ready_o     = busy_q && !rs1_q.pending && !rs2_q.pending;
  assign payload_o   = payload_q;
  assign dest_tag_o  = dest_q;
  assign rs1_value_o = rs1_q.value;
  assign rs2_value_o = rs2_q.value;

endmodule

// File: rtl/rs_bank.sv
// Multi-entry reservation-station bank: allocation from dispatch, operand
// capture from CDB_NUM broadcast ports, and one issue per cycle.
// Ports:
//   clock, reset (sync, active-high)
//   bus (rs_bank_if.slave): squash, alloc_*, cdb_*, issue_*, free_count
// Build option: define RS_AGE_SELECT_EN to select the oldest ready entry
// (age matrix); otherwise the lowest-index ready entry is selected.
module rs_bank
  import rs_pkg::*;
#(
  parameter int unsigned RS_SIZE   = 8,
  parameter int unsigned CDB_NUM   = 2,
  parameter int unsigned TAG_W     = RS_TAG_W,
  parameter int unsigned XLEN      = RS_XLEN,
  parameter int unsigned PAYLOAD_W = 96
) (
  input  logic     clock,
  input  logic     reset,
  rs_bank_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(RS_SIZE) + 1;

  logic [RS_SIZE-1:0]   busy, ready, alloc_we, sel, issue_clr;
  logic                 alloc_fire, alloc_found, issue_fire;
  logic [CNT_W-1:0]     free_cnt;
  rs_src_t              alloc_rs1, alloc_rs2;

  logic [PAYLOAD_W-1:0] slot_payload [RS_SIZE];
  logic [TAG_W-1:0]     slot_dest    [RS_SIZE];
  logic [XLEN-1:0]      slot_rs1     [RS_SIZE];
  logic [XLEN-1:0]      slot_rs2     [RS_SIZE];

  logic [PAYLOAD_W-1:0] issue_payload;
  logic [TAG_W-1:0]     issue_dest;
  logic [XLEN-1:0]      issue_rs1, issue_rs2;

  assign alloc_rs1 = '{pending: bus.alloc_rs1_pending, tag: bus.alloc_rs1_tag,
                       value: bus.alloc_rs1_value};
  assign alloc_rs2 = '{pending: bus.alloc_rs2_pending, tag: bus.alloc_rs2_tag,
                       value: bus.alloc_rs2_value};

  // Free count comes from registered busy bits only, so an issue in the
  // current cycle cannot open a slot for a same-cycle allocation.
  always_comb begin
    free_cnt = CNT_W'(RS_SIZE);
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      free_cnt = free_cnt - CNT_W'(busy[i]);
    end
  end

  assign bus.free_count  = free_cnt;
  assign bus.alloc_ready = (free_cnt != '0);
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready && !bus.squash;

  // Lowest-index free entry.
  always_comb begin
    alloc_we    = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!alloc_found && !busy[i]) begin
        alloc_we[i] = alloc_fire;
        alloc_found = 1'b1;
      end
    end
  end

`ifdef RS_AGE_SELECT_EN
  // older_q[i][j] set: entry i was allocated before entry j. Rows of free
  // entries may hold stale ones; they are cleared when that entry allocates.
  logic [RS_SIZE-1:0] older_q [RS_SIZE];

  always_ff @(posedge clock) begin
    if (reset || bus.squash) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        older_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        for (int unsigned j = 0; j < RS_SIZE; j++) begin
          if (alloc_we[i]) begin
            older_q[i][j] <= 1'b0;
          end else if (alloc_we[j]) begin
            older_q[i][j] <= 1'b1;
          end else if (issue_clr[i]) begin
            older_q[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  // Pick the ready entry that no other ready entry is older than.
  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      sel[i] = ready[i];
      for (int unsigned j = 0; j < RS_SIZE; j++) begin
        if (ready[j] && older_q[j][i]) begin
          sel[i] = 1'b0;
        end
      end
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && (sel == '0)) begin
        sel[i] = 1'b1;
      end
    end
  end
`endif

  assign bus.issue_valid = |ready;
  assign issue_fire      = bus.issue_valid && bus.issue_ready && !bus.squash;
  assign issue_clr       = sel & {RS_SIZE{issue_fire}};

  // One-hot OR mux; all zero when nothing is ready.
  always_comb begin
    issue_payload = '0;
    issue_dest    = '0;
    issue_rs1     = '0;
    issue_rs2     = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (sel[i]) begin
        issue_payload = issue_payload | slot_payload[i];
        issue_dest    = issue_dest | slot_dest[i];
        issue_rs1     = issue_rs1 | slot_rs1[i];
        issue_rs2     = issue_rs2 | slot_rs2[i];
      end
    end
  end

  assign bus.issue_payload   = issue_payload;
  assign bus.issue_dest_tag  = issue_dest;
  assign bus.issue_rs1_value = issue_rs1;
  assign bus.issue_rs2_value = issue_rs2;

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_slot
    rs_slot #(
      .CDB_NUM   (CDB_NUM),
      .PAYLOAD_W (PAYLOAD_W)
    ) u_slot (
      .clk_i            (clock),
      .rst_i            (reset),
      .squash_i         (bus.squash),
      .alloc_we_i       (alloc_we[g]),
      .alloc_payload_i  (bus.alloc_payload),
      .alloc_dest_tag_i (bus.alloc_dest_tag),
      .alloc_rs1_i      (alloc_rs1),
      .alloc_rs2_i      (alloc_rs2),
      .cdb_valid_i      (bus.cdb_valid),
      .cdb_tag_i        (bus.cdb_tag),
      .cdb_value_i      (bus.cdb_value),
      .issue_clr_i      (issue_clr[g]),
      .busy_o           (busy[g]),
      .ready_o          (ready[g]),
      .payload_o        (slot_payload[g]),
      .dest_tag_o       (slot_dest[g]),
      .rs1_value_o      (slot_rs1[g]),
      .rs2_value_o      (slot_rs2[g])
    );
  end

endmodule
